// File: rtl/tpu_optimized.sv
// ---------------------------------------------------------------------------
// tpu_optimized
//   N x N multiply array with per-column summation; compute core of the TPU
//   datapath. Column j result: acc_out[j] = sum_i (d_i * w_j).
//   Three register stages (operands, products, column sums), fixed latency 3.
//   'control' advances every stage together; with control=0 all stages hold.
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset, clears all stages
//   control   in   1          1 = advance pipeline, 0 = freeze
//   data_arr  in   N*DATA_W   d_i at [i*DATA_W +: DATA_W]
//   wt_arr    in   N*DATA_W   w_j at [j*DATA_W +: DATA_W]
//   acc_out   out  N*ACC_W    column j result at [j*ACC_W +: ACC_W]
//
// Configuration
//   TPU_OPT_SIGNED_EN  defined: operands are two's complement, products and
//                      sums are sign-extended to ACC_W.
//                      undefined (default): unsigned, zero-extended.
//   An ACC_W below 2*DATA_W+clog2(N) truncates results modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module tpu_optimized #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                control,
  input  logic [N*DATA_W-1:0] data_arr,
  input  logic [N*DATA_W-1:0] wt_arr,
  output logic [N*ACC_W-1:0]  acc_out
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(N);

`ifdef TPU_OPT_SIGNED_EN
  localparam bit IS_SIGNED = 1'b1;
`else
  localparam bit IS_SIGNED = 1'b0;
`endif

  // Operands are widened to the product width before multiplying, so one
  // multiplier serves both modes: the low PROD_W bits of the widened product
  // equal the true signed (or unsigned) product.
  function automatic logic signed [PROD_W-1:0] pe_mul(
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] w
  );
    logic signed [PROD_W-1:0] dx;
    logic signed [PROD_W-1:0] wx;
    dx = {{DATA_W{IS_SIGNED & d[DATA_W-1]}}, d};
    wx = {{DATA_W{IS_SIGNED & w[DATA_W-1]}}, w};
    return dx * wx;
  endfunction

  // Product to column-sum width (sign- or zero-extension).
  function automatic logic [SUM_W-1:0] ext_sum(input logic [PROD_W-1:0] p);
    logic [SUM_W+PROD_W-1:0] x;
    x = {{SUM_W{IS_SIGNED & p[PROD_W-1]}}, p};
    return x[SUM_W-1:0];
  endfunction

  // Column sum to output width: extends when ACC_W is wider, truncates
  // modulo 2^ACC_W when it is narrower.
  function automatic logic [ACC_W-1:0] fit_acc(input logic [SUM_W-1:0] s);
    logic [ACC_W+SUM_W-1:0] x;
    x = {{ACC_W{IS_SIGNED & s[SUM_W-1]}}, s};
    return x[ACC_W-1:0];
  endfunction

  logic        [DATA_W-1:0] d_p0    [N];
  logic        [DATA_W-1:0] w_p0    [N];
  logic signed [PROD_W-1:0] prod_p1 [N][N];
  logic        [ACC_W-1:0]  acc_p2  [N];

  logic        [SUM_W-1:0]  col_sum [N];
  logic        [ACC_W-1:0]  col_acc [N];

  always_comb begin
    for (int j = 0; j < N; j++) begin
      col_sum[j] = '0;
      for (int i = 0; i < N; i++) begin
        col_sum[j] = col_sum[j] + ext_sum(prod_p1[i][j]);
      end
      col_acc[j] = fit_acc(col_sum[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        d_p0[i]   <= '0;
        w_p0[i]   <= '0;
        acc_p2[i] <= '0;
        for (int j = 0; j < N; j++) begin
          prod_p1[i][j] <= '0;
        end
      end
    end else if (control) begin
      // ---- stage p0: capture operand vectors
      for (int i = 0; i < N; i++) begin
        d_p0[i] <= data_arr[i*DATA_W +: DATA_W];
        w_p0[i] <= wt_arr[i*DATA_W +: DATA_W];
      end
      // ---- stage p1: PE(i,j) product d_i * w_j
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          prod_p1[i][j] <= pe_mul(d_p0[i], w_p0[j]);
        end
      end
      // ---- stage p2: column sums
      for (int j = 0; j < N; j++) begin
        acc_p2[j] <= col_acc[j];
      end
    end
  end

  always_comb begin
    acc_out = '0;
    for (int j = 0; j < N; j++) begin
      acc_out[j*ACC_W +: ACC_W] = acc_p2[j];
    end
  end

endmodule

// File: tb/tb_tpu_optimized.sv
// ---------------------------------------------------------------------------
// tb_tpu_optimized
//   Directed bench for tpu_optimized (N=4, DATA_W=8, ACC_W=24): reset,
//   latency, steady output, asynchronous mid-run reset, hold, max values,
//   streamed inputs with stalls, and signed operands when
//   TPU_OPT_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_tpu_optimized;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;

  logic                clk;
  logic                rst_n;
  logic                control;
  logic [N*DATA_W-1:0] data_arr;
  logic [N*DATA_W-1:0] wt_arr;
  logic [N*ACC_W-1:0]  acc_out;

  int nvec;
  int nmiss;

  tpu_optimized #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .data_arr (data_arr),
    .wt_arr   (wt_arr),
    .acc_out  (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag,
                           input logic [N*ACC_W-1:0] got,
                           input logic [N*ACC_W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DATA_W-1:0] pkd(input int a, input int b,
                                             input int c, input int e);
    logic [N*DATA_W-1:0] r;
    r[0*DATA_W +: DATA_W] = a[DATA_W-1:0];
    r[1*DATA_W +: DATA_W] = b[DATA_W-1:0];
    r[2*DATA_W +: DATA_W] = c[DATA_W-1:0];
    r[3*DATA_W +: DATA_W] = e[DATA_W-1:0];
    return r;
  endfunction

  function automatic logic [N*ACC_W-1:0] pka(input int a, input int b,
                                            input int c, input int e);
    logic [N*ACC_W-1:0] r;
    r[0*ACC_W +: ACC_W] = a[ACC_W-1:0];
    r[1*ACC_W +: ACC_W] = b[ACC_W-1:0];
    r[2*ACC_W +: ACC_W] = c[ACC_W-1:0];
    r[3*ACC_W +: ACC_W] = e[ACC_W-1:0];
    return r;
  endfunction

  function automatic longint elem(input logic [N*DATA_W-1:0] x, input int i);
    logic [DATA_W-1:0] e;
    e = x[i*DATA_W +: DATA_W];
`ifdef TPU_OPT_SIGNED_EN
    return longint'($signed(e));
`else
    return longint'(e);
`endif
  endfunction

  // Column j = w_j * (d_0 + ... + d_{N-1}), taken modulo 2^ACC_W.
  function automatic logic [N*ACC_W-1:0] model(input logic [N*DATA_W-1:0] d,
                                              input logic [N*DATA_W-1:0] w);
    logic [N*ACC_W-1:0] r;
    longint s;
    longint v;
    s = 0;
    for (int i = 0; i < N; i++) s += elem(d, i);
    for (int j = 0; j < N; j++) begin
      v = elem(w, j) * s;
      r[j*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N*DATA_W-1:0] d_tab [8];
  logic [N*DATA_W-1:0] w_tab [8];
  bit                  c_tab [12];
  logic [N*DATA_W-1:0] hist_d [$];
  logic [N*DATA_W-1:0] hist_w [$];

  initial begin
    logic [N*ACC_W-1:0] r1;
    int k;
    nvec = 0;
    nmiss = 0;
    rst_n = 1'b0;
    control = 1'b0;
    data_arr = '0;
    wt_arr = '0;
    r1 = pka(100, 150, 200, 250);

    // reset held across edges
    tick();
    tick();
    check_vec("reset", acc_out, '0);

    // case 1: latency and steady value
    rst_n = 1'b1;
    control = 1'b1;
    data_arr = pkd(5, 10, 15, 20);
    wt_arr = pkd(2, 3, 4, 5);
    tick();
    check_vec("lat_edge1", acc_out, '0);
    tick();
    check_vec("lat_edge2", acc_out, '0);
    tick();
    check_vec("case1_edge3", acc_out, r1);
    tick();
    check_vec("case1_edge4", acc_out, r1);
    tick();
    check_vec("case1_edge5", acc_out, r1);

    // asynchronous reset away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", acc_out, '0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_vec("post_reset_edge2", acc_out, '0);
    tick();
    check_vec("post_reset_edge3", acc_out, r1);

    // hold with changed inputs
    control = 1'b0;
    data_arr = pkd(1, 1, 1, 1);
    wt_arr = pkd(1, 1, 1, 1);
    tick();
    check_vec("hold_edge1", acc_out, r1);
    tick();
    tick();
    check_vec("hold_edge3", acc_out, r1);
    control = 1'b1;
    tick();
    tick();
    check_vec("resume_edge2", acc_out, r1);
    tick();
    check_vec("resume_edge3", acc_out, pka(4, 4, 4, 4));

    // extreme operands
`ifdef TPU_OPT_SIGNED_EN
    data_arr = pkd(-128, -128, -128, -128);
    wt_arr = pkd(-128, -128, -128, -128);
    tick(); tick(); tick();
    check_vec("max_neg", acc_out, pka(65536, 65536, 65536, 65536));
`else
    data_arr = pkd(255, 255, 255, 255);
    wt_arr = pkd(255, 255, 255, 255);
    tick(); tick(); tick();
    check_vec("max_unsigned", acc_out, pka(260100, 260100, 260100, 260100));
`endif

`ifdef TPU_OPT_SIGNED_EN
    data_arr = pkd(-1, -1, -1, -1);
    wt_arr = pkd(2, -3, 4, -5);
    tick(); tick(); tick();
    check_vec("signed", acc_out, pka(-8, 12, -16, 20));
`endif

    // streamed inputs, one new vector per enabled edge, with stalls
    d_tab = '{pkd(1, 2, 3, 4), pkd(9, 0, 0, 7), pkd(200, 17, 33, 1),
              pkd(0, 0, 0, 0), pkd(127, 128, 3, 90), pkd(6, 6, 6, 6),
              pkd(250, 1, 2, 3), pkd(11, 22, 33, 44)};
    w_tab = '{pkd(4, 3, 2, 1), pkd(1, 0, 2, 0), pkd(3, 250, 7, 128),
              pkd(9, 9, 9, 9), pkd(2, 200, 100, 1), pkd(0, 255, 1, 2),
              pkd(5, 5, 5, 5), pkd(13, 14, 15, 16)};
    c_tab = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    k = 0;
    for (int c = 0; c < 12; c++) begin
      control = c_tab[c];
      if (control) begin
        data_arr = d_tab[k % 8];
        wt_arr = w_tab[k % 8];
        hist_d.push_back(data_arr);
        hist_w.push_back(wt_arr);
        k++;
      end else begin
        data_arr = pkd(99, 98, 97, 96);
        wt_arr = pkd(95, 94, 93, 92);
      end
      tick();
      if (k >= 3) begin
        check_vec($sformatf("stream_%0d", c), acc_out,
                  model(hist_d[k-3], hist_w[k-3]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
